pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline CPU. Combines the ID-stage load-use hazard flag, the ID-stage taken-branch signal and the MEM-stage data-memory handshake into one set of pipeline-register enables, flushes and bubbles, with a fixed priority. Tracks multi-cycle data-memory waits with a state machine and a timeout counter, and optionally keeps performance counters. It sits beside the hazard detection unit and drives PC, IF/ID, ID/EX and the back-end pipeline registers.

---
 rtl/pipeline_stall_controller.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//
// Central stall/flush sequencer for the 5-stage pipeline. It merges the
// ID-stage load-use hazard, the ID-stage taken branch and the MEM-stage
// data-memory handshake into pipeline-register enables, flushes and bubbles.
// The fixed priority is freeze > load-use > branch. Multi-cycle memory waits
// are tracked by a RUN / MEM_WAIT / ERR state machine with a timeout counter.
//
// Optional feature macro: STALL_COUNTERS_EN
//   When defined, the stall_cycles_o and flush_count_o saturating
//   performance counters and their ports are present.
//
// Parameters
//   MEM_TIMEOUT  MEM_WAIT cycles without ack before ERR (0 = never time out)
//   CNT_W        performance counter width
//
// Ports
//   clk_i           clock, all state updates on the rising edge
//   rst_i           synchronous active-high reset; forces every output to 0
//   hazard_i        load-use hazard from the hazard detection unit
//   branch_taken_i  branch in ID resolved taken this cycle
//   mem_req_i       MEM stage data-memory access, held until acknowledged
//   mem_ack_i       data-memory completion, data valid this cycle
//   pc_write_o      PC load enable
//   ifid_write_o    IF/ID load enable
//   ifid_flush_o    IF/ID clear (inserts NOP)
//   idex_bubble_o   zero ID/EX control fields
//   pipe_freeze_o   hold ID/EX, EX/MEM and MEM/WB
//   err_o           sticky memory-timeout error
//   state_o         0 RUN, 1 MEM_WAIT, 2 ERR
//   stall_cycles_o  cycles with pc_write_o=0 (STALL_COUNTERS_EN only)
//   flush_count_o   cycles with ifid_flush_o=1 (STALL_COUNTERS_EN only)

module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hazard_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic             err_o,
    output logic [1:0]       state_o
`ifdef STALL_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
`endif
);

    // Width must hold 0..MEM_TIMEOUT, but never shrink below one bit.
    localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT =
        WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                err_q, err_d;
    logic                freeze;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Dropping mem_req_i in MEM_WAIT without an ack is a protocol violation;
    // only the ack returns us to RUN, so req is deliberately not looked at.
    // An ack in the timeout-limit cycle takes precedence over ERR.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (mem_ack_i) begin
                    state_d = ST_RUN;
                end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_LIMIT)) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
                err_d   = 1'b1;
            end
        endcase
    end

    // Outputs are purely combinational from state and inputs. A frozen
    // back end masks hazard and branch; they are re-evaluated on release.
    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_freeze_o = 1'b0;
        unique case (state_q)
            ST_RUN:  freeze = mem_req_i & ~mem_ack_i;
            ST_WAIT: freeze = ~mem_ack_i;
            default: freeze = 1'b1;
        endcase
        if (!rst_i) begin
            if (freeze) begin
                pipe_freeze_o = 1'b1;
            end else if (hazard_i) begin
                idex_bubble_o = 1'b1;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                ifid_flush_o = branch_taken_i;
            end
        end
    end

    assign err_o   = rst_i ? 1'b0 : err_q;
    assign state_o = rst_i ? 2'b00 : state_q;

`ifdef STALL_COUNTERS_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // Saturating counters: they stick at all-ones instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_write_o && !(&stall_q)) begin
            stall_d = stall_q + 1'b1;
        end
        if (ifid_flush_o && !(&flush_q)) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles_o = rst_i ? '0 : stall_q;
    assign flush_count_o  = rst_i ? '0 : flush_q;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed testbench for pipeline_stall_controller (MEM_TIMEOUT=4, CNT_W=4).
// Observed output bundle: {pc_write, ifid_write, ifid_flush, idex_bubble,
// pipe_freeze, err, state[1:0]}.

module tb_pipeline_stall_controller;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    logic clk_i = 1'b0;
    logic rst_i, hazard_i, branch_taken_i, mem_req_i, mem_ack_i;
    logic pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o, err_o;
    logic [1:0] state_o;
`ifdef STALL_COUNTERS_EN
    logic [CNT_W-1:0] stall_cycles_o, flush_count_o;
`endif

    int testCount = 0;
    int failCount = 0;

    pipeline_stall_controller #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .hazard_i      (hazard_i),
        .branch_taken_i(branch_taken_i),
        .mem_req_i     (mem_req_i),
        .mem_ack_i     (mem_ack_i),
        .pc_write_o    (pc_write_o),
        .ifid_write_o  (ifid_write_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_bubble_o (idex_bubble_o),
        .pipe_freeze_o (pipe_freeze_o),
        .err_o         (err_o),
        .state_o       (state_o)
`ifdef STALL_COUNTERS_EN
        ,
        .stall_cycles_o(stall_cycles_o),
        .flush_count_o (flush_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] outs();
        return {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
                pipe_freeze_o, err_o, state_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic rst, input logic hz, input logic br,
                         input logic req, input logic ack);
        rst_i          = rst;
        hazard_i       = hz;
        branch_taken_i = br;
        mem_req_i      = req;
        mem_ack_i      = ack;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset with busy inputs must still force every output low.
    task automatic test_reset();
        logic [7:0] obs;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            obs = outs();
            testCount++;
            if (obs !== 8'b0000_0000) begin
                failCount++;
                $display("[TB] FAIL reset_c%0d: got %b expected %b", i, obs, 8'b0000_0000);
            end
`ifdef STALL_COUNTERS_EN
            testCount++;
            if (stall_cycles_o !== 4'd0 || flush_count_o !== 4'd0) begin
                failCount++;
                $display("[TB] FAIL reset_cnt_c%0d: got %0d/%0d expected 0/0", i, stall_cycles_o, flush_count_o);
            end
`endif
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        obs = outs();
        testCount++;
        if (obs !== 8'b1100_0000) begin
            failCount++;
            $display("[TB] FAIL reset_idle: got %b expected %b", obs, 8'b1100_0000);
        end
        tick();
    endtask

    // Inputs per row: {hazard, branch, req, ack}.
    task automatic test_hazard_branch();
        logic [3:0] vin [3] = '{4'b1100, 4'b0100, 4'b0000};
        logic [7:0] vexp [3] = '{8'b0001_0000, 8'b1110_0000, 8'b1100_0000};
        logic [7:0] obs;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, vin[i][3], vin[i][2], vin[i][1], vin[i][0]);
            @(negedge clk_i);
            obs = outs();
            testCount++;
            if (obs !== vexp[i]) begin
                failCount++;
                $display("[TB] FAIL hazard_branch_c%0d: got %b expected %b", i, obs, vexp[i]);
            end
            tick();
        end
`ifdef STALL_COUNTERS_EN
        testCount++;
        if (stall_cycles_o !== 4'd1 || flush_count_o !== 4'd1) begin
            failCount++;
            $display("[TB] FAIL hazard_branch_cnt: got %0d/%0d expected 1/1", stall_cycles_o, flush_count_o);
        end
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mem_wait();
        logic [3:0] vin [5] = '{4'b0010, 4'b1110, 4'b0010, 4'b0011, 4'b0000};
        logic [7:0] vexp [5] = '{8'b0000_1000, 8'b0000_1001, 8'b0000_1001,
                                 8'b1100_0001, 8'b1100_0000};
        logic [7:0] obs;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, vin[i][3], vin[i][2], vin[i][1], vin[i][0]);
            @(negedge clk_i);
            obs = outs();
            testCount++;
            if (obs !== vexp[i]) begin
                failCount++;
                $display("[TB] FAIL mem_wait_c%0d: got %b expected %b", i, obs, vexp[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vin [3] = '{4'b0011, 4'b0111, 4'b0000};
        logic [7:0] vexp [3] = '{8'b1100_0000, 8'b1110_0000, 8'b1100_0000};
        logic [7:0] obs;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, vin[i][3], vin[i][2], vin[i][1], vin[i][0]);
            @(negedge clk_i);
            obs = outs();
            testCount++;
            if (obs !== vexp[i]) begin
                failCount++;
                $display("[TB] FAIL zero_latency_c%0d: got %b expected %b", i, obs, vexp[i]);
            end
            tick();
        end
    endtask

    // req dropped in MEM_WAIT without ack: stays frozen in MEM_WAIT.
    task automatic test_protocol();
        logic [3:0] vin [5] = '{4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        logic [7:0] vexp [5] = '{8'b0000_1000, 8'b0000_1001, 8'b0000_1001,
                                 8'b1100_0001, 8'b1100_0000};
        logic [7:0] obs;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, vin[i][3], vin[i][2], vin[i][1], vin[i][0]);
            @(negedge clk_i);
            obs = outs();
            testCount++;
            if (obs !== vexp[i]) begin
                failCount++;
                $display("[TB] FAIL protocol_c%0d: got %b expected %b", i, obs, vexp[i]);
            end
            tick();
        end
    endtask

    // 1 RUN cycle + 4 MEM_WAIT cycles frozen, then ERR; later ack ignored.
    task automatic test_timeout();
        logic [3:0] vin [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                4'b0010, 4'b0010, 4'b0011, 4'b0000};
        logic [7:0] vexp [8] = '{8'b0000_1000, 8'b0000_1001, 8'b0000_1001, 8'b0000_1001,
                                 8'b0000_1001, 8'b0000_1110, 8'b0000_1110, 8'b0000_1110};
        logic [7:0] obs;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, vin[i][3], vin[i][2], vin[i][1], vin[i][0]);
            @(negedge clk_i);
            obs = outs();
            testCount++;
            if (obs !== vexp[i]) begin
                failCount++;
                $display("[TB] FAIL timeout_c%0d: got %b expected %b", i, obs, vexp[i]);
            end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        obs = outs();
        testCount++;
        if (obs !== 8'b0000_0000) begin
            failCount++;
            $display("[TB] FAIL timeout_in_reset: got %b expected %b", obs, 8'b0000_0000);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        obs = outs();
        testCount++;
        if (obs !== 8'b1100_0000) begin
            failCount++;
            $display("[TB] FAIL timeout_cleared: got %b expected %b", obs, 8'b1100_0000);
        end
        tick();
    endtask

    // Ack in the 4th MEM_WAIT cycle (the limit cycle) beats the timeout.
    task automatic test_timeout_boundary();
        logic [3:0] vin [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0000};
        logic [7:0] vexp [6] = '{8'b0000_1000, 8'b0000_1001, 8'b0000_1001,
                                 8'b0000_1001, 8'b1100_0001, 8'b1100_0000};
        logic [7:0] obs;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, vin[i][3], vin[i][2], vin[i][1], vin[i][0]);
            @(negedge clk_i);
            obs = outs();
            testCount++;
            if (obs !== vexp[i]) begin
                failCount++;
                $display("[TB] FAIL boundary_c%0d: got %b expected %b", i, obs, vexp[i]);
            end
            tick();
        end
    endtask

    // 20 consecutive load-use cycles: a bubble each cycle, counter saturates.
    task automatic test_hazard_saturation();
        logic [7:0] obs;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk_i);
            obs = outs();
            testCount++;
            if (obs !== 8'b0001_0000) begin
                failCount++;
                $display("[TB] FAIL hazard_run_c%0d: got %b expected %b", i, obs, 8'b0001_0000);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
`ifdef STALL_COUNTERS_EN
        testCount++;
        if (stall_cycles_o !== 4'd15 || flush_count_o !== 4'd0) begin
            failCount++;
            $display("[TB] FAIL saturation: got %0d/%0d expected 15/0", stall_cycles_o, flush_count_o);
        end
`endif
        tick();
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_hazard_branch();
        test_mem_wait();
        test_back_to_back();
        test_protocol();
        test_timeout();
        test_timeout_boundary();
        test_hazard_saturation();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
